// File: rtl/dense_layer_engine.sv
// Fully-connected layer datapath: one signed MAC lane per output neuron,
// followed by bias add, optional ReLU and saturation to the output width.
//
// state    | meaning
// IDLE     | waiting for run; clears lanes and counter on start
// ACCUM    | accepts one input index per cycle when a_q matches cnt
// BIAS     | adds bias (aligned to the Q point) to every lane
// ACT      | shift, ReLU, saturate, write outputs, raise done
// DONE     | done pulse cycle
// WAIT_LOW | holds until run is released so a layer cannot retrigger
module dense_layer_engine #(
  parameter int N_IN  = 784,
  parameter int N_OUT = 128,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 40,
  parameter int RELU  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [31:0]           addr,
  input  logic [DW-1:0]         in_data,
  input  logic [N_OUT*DW-1:0]   w_data,
  input  logic [N_OUT*DW-1:0]   b_data,
  output logic [N_OUT*DW-1:0]   out_data,
  output logic                  out_valid,
  output logic                  done,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCUM, S_BIAS, S_ACT, S_DONE, S_WAIT_LOW
  } state_t;

  localparam int CW = $clog2(N_IN + 1);

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [31:0]             r_a_q;
  logic                    r_v_q;
  logic signed [ACC_W-1:0] r_acc [N_OUT];
  logic [N_OUT*DW-1:0]     r_out_data;
  logic                    r_out_valid;
  logic                    r_done;
  logic                    r_busy;
  logic                    w_hit;

  // An index is accepted only once, and only in order.
  assign w_hit = r_v_q && (r_a_q == 32'(r_cnt));

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign done      = r_done;
  assign busy      = r_busy;

  function automatic logic signed [ACC_W-1:0] f_mac(input logic [DW-1:0] a,
                                                    input logic [DW-1:0] b);
    logic signed [2*DW-1:0] p;
    p = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
    return ACC_W'(p);
  endfunction

  function automatic logic [DW-1:0] f_act(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    logic                    ovf_hi;
    logic                    ovf_lo;
    r = acc >>> FRAC;
    if (RELU != 0 && r[ACC_W-1]) r = '0;
    // Saturate when the bits above the output sign bit are not all equal to it.
    ovf_hi = !r[ACC_W-1] && (r[ACC_W-1:DW-1] != '0);
    ovf_lo =  r[ACC_W-1] && (r[ACC_W-1:DW-1] != '1);
    if (ovf_hi)      return {1'b0, {(DW-1){1'b1}}};
    else if (ovf_lo) return {1'b1, {(DW-1){1'b0}}};
    else             return r[DW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_a_q       <= '0;
      r_v_q       <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      for (int j = 0; j < N_OUT; j++) r_acc[j] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (run) begin
            for (int j = 0; j < N_OUT; j++) r_acc[j] <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_a_q       <= addr;
            r_v_q       <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          r_a_q <= addr;
          r_v_q <= run;
          if (w_hit) begin
            for (int j = 0; j < N_OUT; j++)
              r_acc[j] <= r_acc[j] + f_mac(in_data, w_data[j*DW +: DW]);
            r_cnt <= r_cnt + CW'(1);
          end
          if (!run) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_hit && r_cnt == CW'(N_IN - 1)) begin
            r_state <= S_BIAS;
          end
        end
        S_BIAS: begin
          for (int j = 0; j < N_OUT; j++)
            r_acc[j] <= r_acc[j] + (ACC_W'($signed(b_data[j*DW +: DW])) <<< FRAC);
          r_state <= S_ACT;
        end
        S_ACT: begin
          for (int j = 0; j < N_OUT; j++)
            r_out_data[j*DW +: DW] <= f_act(r_acc[j]);
          r_out_valid <= 1'b1;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          r_state <= run ? S_WAIT_LOW : S_IDLE;
        end
        S_WAIT_LOW: begin
          if (!run) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_engine.sv
// Scoreboard bench for dense_layer_engine: two instances (ReLU on/off) share
// stimulus; a layer-level arithmetic model predicts each done event.
module tb_dense_layer_engine;
  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int ACC_W = 40;

  typedef struct {
    int start;
    int dly;
    int v0;
    int v1;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                run = 1'b0;
  logic [31:0]         addr = '0;
  logic [DW-1:0]       in_data = '0;
  logic [N_OUT*DW-1:0] w_data = '0;
  logic [N_OUT*DW-1:0] b_data = '0;
  logic [N_OUT*DW-1:0] out_r, out_n;
  logic                ov_r, ov_n, done_r, done_n, busy_r, busy_n;

  dense_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC),
                       .ACC_W(ACC_W), .RELU(1)) u_dut (
    .clk(clk), .rst(rst), .run(run), .addr(addr), .in_data(in_data),
    .w_data(w_data), .b_data(b_data), .out_data(out_r), .out_valid(ov_r),
    .done(done_r), .busy(busy_r));

  dense_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC),
                       .ACC_W(ACC_W), .RELU(0)) u_dut_nr (
    .clk(clk), .rst(rst), .run(run), .addr(addr), .in_data(in_data),
    .w_data(w_data), .b_data(b_data), .out_data(out_n), .out_valid(ov_n),
    .done(done_n), .busy(busy_n));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   act_v [N_IN];
  int   w_v   [N_IN][N_OUT];
  int   b_v   [N_OUT];
  int   prev_addr = 0;
  exp_t q_r[$];
  exp_t q_n[$];

  task automatic chk(input string name, input longint got, input longint want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Layer result from plain arithmetic: dot product, bias in Q format, floor shift.
  function automatic int model_lane(input int j, input bit relu);
    longint acc = 0;
    longint r;
    for (int i = 0; i < N_IN; i++) acc += longint'(act_v[i]) * longint'(w_v[i][j]);
    acc += longint'(b_v[j]) * (longint'(1) << FRAC);
    r = acc >>> FRAC;
    if (relu && r < 0) r = 0;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  task automatic mon(input bit nr);
    exp_t e;
    logic [N_OUT*DW-1:0] od;
    logic ov;
    od = nr ? out_n : out_r;
    ov = nr ? ov_n : ov_r;
    if ((nr ? q_n.size() : q_r.size()) == 0) begin
      chk(nr ? "unexpected_done_nr" : "unexpected_done", 1, 0);
      return;
    end
    e = nr ? q_n.pop_front() : q_r.pop_front();
    chk(nr ? "done_cycle_nr" : "done_cycle", cyc - e.start, e.dly);
    chk(nr ? "out_valid_nr" : "out_valid", ov, 1);
    chk(nr ? "lane0_nr" : "lane0", $signed(od[DW-1:0]), e.v0);
    chk(nr ? "lane1_nr" : "lane1", $signed(od[2*DW-1:DW]), e.v1);
  endtask

  always @(negedge clk) begin
    if (!rst && done_r) mon(1'b0);
    if (!rst && done_n) mon(1'b1);
  end

  // Emulates the 1-cycle-latency activation/weight memories.
  task automatic drive_now(input logic r, input int a);
    if (prev_addr < N_IN) begin
      in_data = DW'(act_v[prev_addr]);
      for (int j = 0; j < N_OUT; j++) w_data[j*DW +: DW] = DW'(w_v[prev_addr][j]);
    end else begin
      in_data = DW'($urandom);
      w_data  = (N_OUT*DW)'($urandom);
    end
    run       = r;
    addr      = 32'(a);
    prev_addr = a;
  endtask

  task automatic run_layer(input int seq[$], input int tail, input bit expect_done);
    int   k = -1;
    int   start;
    exp_t e;
    for (int i = 0; i < seq.size(); i++) if (k < 0 && seq[i] == N_IN - 1) k = i;
    for (int j = 0; j < N_OUT; j++) b_data[j*DW +: DW] = DW'(b_v[j]);
    @(negedge clk);
    start = cyc;
    if (expect_done) begin
      e.start = start; e.dly = k + 4;
      e.v0 = model_lane(0, 1'b1); e.v1 = model_lane(1, 1'b1);
      q_r.push_back(e);
      e.v0 = model_lane(0, 1'b0); e.v1 = model_lane(1, 1'b0);
      q_n.push_back(e);
    end
    for (int i = 0; i < seq.size(); i++) begin
      drive_now(1'b1, seq[i]);
      @(negedge clk);
      if (i == 0) begin
        chk("busy_on_start", busy_r, 1);
        chk("out_valid_cleared_on_start", ov_r, 0);
        chk("out_valid_cleared_on_start_nr", ov_n, 0);
      end
    end
    for (int i = 0; i < tail; i++) begin
      drive_now(1'b1, N_IN - 1);
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      drive_now(1'b0, 0);
      @(negedge clk);
    end
    chk("done_seen", q_r.size(), 0);
    chk("done_seen_nr", q_n.size(), 0);
    q_r.delete();
    q_n.delete();
  endtask

  task automatic set_nominal();
    for (int i = 0; i < N_IN; i++) begin
      act_v[i] = 256; w_v[i][0] = 128; w_v[i][1] = -128;
    end
    b_v[0] = 64; b_v[1] = 0;
  endtask

  task automatic check_nominal_result(input string tag);
    chk({tag, "_lane0"}, $signed(out_r[DW-1:0]), 576);
    chk({tag, "_lane1"}, $signed(out_r[2*DW-1:DW]), 0);
    chk({tag, "_lane1_nr"}, $signed(out_n[2*DW-1:DW]), -512);
    chk({tag, "_valid"}, ov_r, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_data"}, out_r, 0);
    chk({tag, "_out_valid"}, ov_r, 0);
    chk({tag, "_done"}, done_r, 0);
    chk({tag, "_busy"}, busy_r, 0);
    chk({tag, "_out_data_nr"}, out_n, 0);
    chk({tag, "_busy_nr"}, busy_n, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[$];
    int a;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    set_nominal();
    seq = '{0, 1, 2, 3};
    run_layer(seq, 5, 1'b1);
    check_nominal_result("nominal");

    seq = '{0, 1, 2, 2, 2, 3, 3, 3};
    run_layer(seq, 5, 1'b1);
    check_nominal_result("held");

    for (int i = 0; i < N_IN; i++) begin
      act_v[i] = 32512; w_v[i][0] = 32512; w_v[i][1] = -32512;
    end
    b_v[0] = 0; b_v[1] = 0;
    seq = '{0, 1, 2, 3};
    run_layer(seq, 5, 1'b1);
    chk("sat_lane0", $signed(out_r[DW-1:0]), 32767);
    chk("sat_lane1_relu", $signed(out_r[2*DW-1:DW]), 0);
    chk("sat_lane1_norelu", $signed(out_n[2*DW-1:DW]), -32768);

    set_nominal();
    seq = '{0, 1, 2};
    run_layer(seq, 0, 1'b0);
    chk("abort_out_valid", ov_r, 0);
    chk("abort_busy", busy_r, 0);
    seq = '{0, 1, 2, 3};
    run_layer(seq, 5, 1'b1);
    check_nominal_result("rerun_after_abort");

    run_layer(seq, 15, 1'b1);
    run_layer(seq, 5, 1'b1);
    check_nominal_result("after_no_retrigger");

    @(negedge clk);
    drive_now(1'b1, 0); @(negedge clk);
    drive_now(1'b1, 1); @(negedge clk);
    drive_now(1'b1, 2); rst = 1'b1; @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b0;
    drive_now(1'b0, 0); @(negedge clk);
    run_layer(seq, 5, 1'b1);
    check_nominal_result("rerun_after_reset");

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N_IN; i++) begin
        act_v[i] = int'($urandom_range(0, 65535)) - 32768;
        for (int j = 0; j < N_OUT; j++) w_v[i][j] = int'($urandom_range(0, 65535)) - 32768;
      end
      for (int j = 0; j < N_OUT; j++) b_v[j] = int'($urandom_range(0, 65535)) - 32768;
      seq = '{0};
      a = 0;
      while (a < N_IN - 1) begin
        if ($urandom_range(0, 2) != 0) a++;
        seq.push_back(a);
      end
      run_layer(seq, 5 + int'($urandom_range(0, 4)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
